// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - CPU-side bundle of the UART receive FIFO
// Purpose: groups the receive FIFO head, status and control strobes.
// Ports (master = receiver, slave = CPU side):
//   rx_data, rx_err_parity, rx_err_frame : head entry of the FIFO
//   rx_ready, rx_count, overflow         : FIFO status
//   rx_ack, ovf_clr                      : pop strobe, sticky overflow clear
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int AW        = 2
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_err_parity;
    logic                 rx_err_frame;
    logic                 rx_ready;
    logic                 rx_ack;
    logic [AW:0]          rx_count;
    logic                 overflow;
    logic                 ovf_clr;

    modport master (
        output rx_data, rx_err_parity, rx_err_frame, rx_ready, rx_count, overflow,
        input  rx_ack, ovf_clr
    );

    modport slave (
        input  rx_data, rx_err_parity, rx_err_frame, rx_ready, rx_count, overflow,
        output rx_ack, ovf_clr
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with start-bit validation and error-flagged FIFO
// Purpose: decodes async frames (DATA_BITS, PARITY, STOP_BITS) from rx and
// queues {frame_err, parity_err, data} in a power-of-two FIFO.
// Ports:
//   clk    : system clock, rising edge
//   resetn : asynchronous active-low reset
//   rx     : serial line, idle high, asynchronous to clk
//   bus    : CPU-side FIFO head/status/control (uart_rx_fifo_if.master)
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 125_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic rx,
    uart_rx_fifo_if.master bus
);
    localparam int BAUD_CNT = CLK_FREQ / BAUD;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int W        = DATA_BITS + 2;

    localparam logic [15:0]   FULL_RELOAD = 16'(BAUD_CNT - 1);
    localparam logic [15:0]   HALF_RELOAD = 16'(BAUD_CNT / 2 - 1);
    localparam logic [3:0]    LAST_BIT    = 4'(DATA_BITS - 1);
    localparam logic          LAST_STOP   = 1'(STOP_BITS - 1);
    localparam logic          ODD         = (PARITY == 2);
    localparam logic [AW:0]   DEPTH       = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_BREAK = 3'd5;

    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_d;
    logic [2:0]           state;
    logic [15:0]          cnt;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr;
    logic                 ferr;

    logic                 cnt_zero;
    logic                 frame_err;
    logic                 push;
    logic [W-1:0]         push_word;

    logic [W-1:0]         storage [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 overflow;
    logic                 full;
    logic                 pop;
    logic                 wr_en;

    // Two-flop synchroniser plus one delay flop for falling-edge detection;
    // all reset high so a reset never looks like a start condition.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign cnt_zero  = (cnt == 16'd0);
    assign frame_err = ferr | ~rx_s;
    // The push is issued in the cycle of the last stop sample, so the word
    // carries that sample's framing result directly.
    assign push      = (state == S_STOP) && cnt_zero && (stop_idx == LAST_STOP);
    assign push_word = {frame_err, perr, shreg};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            cnt      <= 16'd0;
            bit_idx  <= 4'd0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_d && !rx_s) begin
                        cnt   <= HALF_RELOAD;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_zero) begin
                        // A line that is high again at mid start bit was a glitch.
                        if (rx_s) begin
                            state <= S_IDLE;
                        end else begin
                            cnt      <= FULL_RELOAD;
                            bit_idx  <= 4'd0;
                            stop_idx <= 1'b0;
                            perr     <= 1'b0;
                            ferr     <= 1'b0;
                            state    <= S_DATA;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (cnt_zero) begin
                        // LSB arrives first; shifting right lands it at bit 0.
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        cnt   <= FULL_RELOAD;
                        if (bit_idx == LAST_BIT) begin
                            state <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_PAR: begin
                    if (cnt_zero) begin
                        perr  <= (((^shreg) ^ rx_s) != ODD);
                        cnt   <= FULL_RELOAD;
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (cnt_zero) begin
                        if (stop_idx == LAST_STOP) begin
                            // A low final stop bit may be a held-low line; wait
                            // for idle so it yields one entry, not a stream.
                            state <= rx_s ? S_IDLE : S_BREAK;
                        end else begin
                            ferr     <= frame_err;
                            stop_idx <= 1'b1;
                            cnt      <= FULL_RELOAD;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign full  = (count == DEPTH);
    assign pop   = bus.rx_ack && (count != '0);
    // When full, a same-cycle pop frees the slot being written.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                storage[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                storage[wr_ptr] <= push_word;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
            // A drop in the same cycle as a clear keeps the flag set.
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end else if (bus.ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign bus.rx_data       = storage[rd_ptr][DATA_BITS-1:0];
    assign bus.rx_err_parity = storage[rd_ptr][DATA_BITS];
    assign bus.rx_err_frame  = storage[rd_ptr][DATA_BITS+1];
    assign bus.rx_ready      = (count != '0);
    assign bus.rx_count      = count;
    assign bus.overflow      = overflow;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo (8N1 and 8E1 instances)
module tb_uart_rx_fifo;
    localparam int CF = 1_600_000;
    localparam int BD = 100_000;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic rx_n   = 1'b1;
    logic rx_p   = 1'b1;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_BITS(8), .AW(2)) bn ();
    uart_rx_fifo_if #(.DATA_BITS(8), .AW(2)) bp ();

    uart_rx_fifo #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_n (
        .clk(clk), .resetn(resetn), .rx(rx_n), .bus(bn));

    uart_rx_fifo #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_p (
        .clk(clk), .resetn(resetn), .rx(rx_p), .bus(bp));

    // Reference model: one queue of {ferr, perr, data} per instance.
    logic [9:0] q_n[$];
    logic [9:0] q_p[$];
    bit   ovf_m [2];
    bit   mv    [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int last_start = 0;
    logic prev_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bn.rx_ready && !prev_rdy) rise_cyc <= cyc;
        prev_rdy <= bn.rx_ready;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int msize(input int w);
        return (w == 0) ? q_n.size() : q_p.size();
    endfunction

    function automatic logic [9:0] mhead(input int w);
        if (w == 0) return (q_n.size() > 0) ? q_n[0] : 10'h0;
        return (q_p.size() > 0) ? q_p[0] : 10'h0;
    endfunction

    task automatic mpush(input int w, input logic [9:0] word);
        if (msize(w) < 4) begin
            if (w == 0) q_n.push_back(word); else q_p.push_back(word);
        end else begin
            ovf_m[w] = 1'b1;
        end
    endtask

    task automatic mpop(input int w);
        if (msize(w) > 0) begin
            if (w == 0) void'(q_n.pop_front()); else void'(q_p.pop_front());
        end
    endtask

    task automatic mclear();
        q_n.delete();
        q_p.delete();
        ovf_m[0] = 1'b0;
        ovf_m[1] = 1'b0;
    endtask

    task automatic rd(input int w, output logic [2:0] c, output logic r, output logic o,
                      output logic [7:0] d, output logic pe, output logic fe);
        if (w == 0) begin
            c = bn.rx_count; r = bn.rx_ready; o = bn.overflow;
            d = bn.rx_data; pe = bn.rx_err_parity; fe = bn.rx_err_frame;
        end else begin
            c = bp.rx_count; r = bp.rx_ready; o = bp.overflow;
            d = bp.rx_data; pe = bp.rx_err_parity; fe = bp.rx_err_frame;
        end
    endtask

    task automatic cmp(input int w);
        logic [2:0] c; logic r, o, pe, fe; logic [7:0] d; logic [9:0] h; int n;
        rd(w, c, r, o, d, pe, fe);
        n = msize(w);
        h = mhead(w);
        chk(w == 0 ? "n_count" : "p_count", c, n);
        chk(w == 0 ? "n_ready" : "p_ready", r, n != 0);
        chk(w == 0 ? "n_overflow" : "p_overflow", o, ovf_m[w]);
        if (n > 0) begin
            chk(w == 0 ? "n_data" : "p_data", d, h[7:0]);
            chk(w == 0 ? "n_perr" : "p_perr", pe, h[8]);
            chk(w == 0 ? "n_ferr" : "p_ferr", fe, h[9]);
        end
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (mv[0]) cmp(0);
            if (mv[1]) cmp(1);
        end
    end

    task automatic head_is(input int w, input string nm, input logic [7:0] ed,
                           input logic epe, input logic efe);
        logic [2:0] c; logic r, o, pe, fe; logic [7:0] d;
        rd(w, c, r, o, d, pe, fe);
        chk({nm, "_data"}, d, ed);
        chk({nm, "_perr"}, pe, epe);
        chk({nm, "_ferr"}, fe, efe);
    endtask

    task automatic status_is(input int w, input string nm, input int ec, input logic eo);
        logic [2:0] c; logic r, o, pe, fe; logic [7:0] d;
        rd(w, c, r, o, d, pe, fe);
        chk({nm, "_count"}, c, ec);
        chk({nm, "_ready"}, r, ec != 0);
        chk({nm, "_ovf"}, o, eo);
    endtask

    task automatic reset_outputs_are(input int w, input string nm);
        logic [2:0] c; logic r, o, pe, fe; logic [7:0] d;
        rd(w, c, r, o, d, pe, fe);
        chk({nm, "_count"}, c, 0);
        chk({nm, "_ready"}, r, 0);
        chk({nm, "_ovf"}, o, 0);
        chk({nm, "_data"}, d, 0);
        chk({nm, "_perr"}, pe, 0);
        chk({nm, "_ferr"}, fe, 0);
    endtask

    // One bit = 16 clocks; start bit driven at negedge k=0. Optional rx_ack
    // at the push edge, optional reset pulse at negedge rst_k.
    task automatic send_frame(input int w, input logic [7:0] d, input bit par_bad,
                              input bit stop_bad, input bit ack_at_push, input int rst_k);
        logic [10:0] bits; int nbits; int ack_k; int b; bit aborted; logic lvl;
        aborted = 1'b0;
        nbits = (w == 1) ? 11 : 10;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (w == 1) begin
            bits[9]  = (^d) ^ par_bad;
            bits[10] = ~stop_bad;
        end else begin
            bits[9] = ~stop_bad;
        end
        ack_k = 16 * (nbits - 1) + 10;
        mv[w] = 1'b0;
        for (int k = 0; k < nbits * 16 + 16; k++) begin
            @(negedge clk);
            if (k == 0) last_start = cyc;
            b = k / 16;
            lvl = (b < nbits) ? bits[b] : 1'b1;
            if (w == 0) rx_n = lvl; else rx_p = lvl;
            if (ack_at_push) begin
                if (w == 0) bn.rx_ack = (k == ack_k); else bp.rx_ack = (k == ack_k);
            end
            if (k == rst_k) begin
                resetn = 1'b0;
                mv[0] = 1'b0;
                mv[1] = 1'b0;
                aborted = 1'b1;
                mclear();
            end
            if (rst_k >= 0 && k == rst_k + 2) reset_outputs_are(0, "midreset");
            if (rst_k >= 0 && k == rst_k + 4) resetn = 1'b1;
        end
        if (!aborted) begin
            if (ack_at_push) mpop(w);
            mpush(w, {stop_bad, (w == 1) ? par_bad : 1'b0, d});
            mv[w] = 1'b1;
        end else begin
            mv[0] = 1'b1;
            mv[1] = 1'b1;
        end
    endtask

    task automatic pop(input int w);
        @(negedge clk);
        if (w == 0) bn.rx_ack = 1'b1; else bp.rx_ack = 1'b1;
        @(posedge clk);
        #1;
        mpop(w);
        bn.rx_ack = 1'b0;
        bp.rx_ack = 1'b0;
    endtask

    task automatic clr(input int w);
        @(negedge clk);
        if (w == 0) bn.ovf_clr = 1'b1; else bp.ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_m[w] = 1'b0;
        bn.ovf_clr = 1'b0;
        bp.ovf_clr = 1'b0;
    endtask

    initial begin
        int w; logic [7:0] d; bit pb, sb; int npop;
        bn.rx_ack = 1'b0; bn.ovf_clr = 1'b0;
        bp.rx_ack = 1'b0; bp.ovf_clr = 1'b0;
        mv[0] = 1'b0; mv[1] = 1'b0;
        mclear();

        repeat (3) @(negedge clk);
        reset_outputs_are(0, "rst_n");
        reset_outputs_are(1, "rst_p");
        resetn = 1'b1;
        mv[0] = 1'b1; mv[1] = 1'b1;
        repeat (4) @(negedge clk);

        // 8N1 0xA5: ready rises one clock after the stop-centre sample.
        send_frame(0, 8'hA5, 0, 0, 0, -1);
        chk("a5_latency", rise_cyc - last_start, 155);
        head_is(0, "a5", 8'hA5, 0, 0);
        status_is(0, "a5", 1, 0);
        pop(0);
        status_is(0, "a5_pop", 0, 0);

        // 4-clock glitch: rejected, then a real frame right after.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rx_n = 1'b0;
        end
        @(negedge clk);
        rx_n = 1'b1;
        repeat (12) @(negedge clk);
        status_is(0, "glitch", 0, 0);
        send_frame(0, 8'h3C, 0, 0, 0, -1);
        head_is(0, "after_glitch", 8'h3C, 0, 0);
        pop(0);

        // Even parity: 0x07 has odd weight, correct parity bit is 1.
        send_frame(1, 8'h07, 1, 0, 0, -1);
        head_is(1, "par_bad", 8'h07, 1, 0);
        pop(1);
        send_frame(1, 8'h07, 0, 0, 0, -1);
        head_is(1, "par_ok", 8'h07, 0, 0);
        pop(1);

        // Line held low for 30 bit times: one entry with framing error.
        mv[0] = 1'b0;
        repeat (480) begin @(negedge clk); rx_n = 1'b0; end
        repeat (32)  begin @(negedge clk); rx_n = 1'b1; end
        mpush(0, {1'b1, 1'b0, 8'h00});
        mv[0] = 1'b1;
        status_is(0, "break", 1, 0);
        head_is(0, "break", 8'h00, 0, 1);
        pop(0);
        send_frame(0, 8'h81, 0, 0, 0, -1);
        head_is(0, "after_break", 8'h81, 0, 0);
        pop(0);

        // Overflow: fifth word dropped.
        for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 0, 0, 0, -1);
        status_is(0, "ovf", 4, 1);
        head_is(0, "ovf_head", 8'h01, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            head_is(0, "ovf_drain", 8'(i), 0, 0);
            pop(0);
        end
        clr(0);
        status_is(0, "ovf_clr", 0, 0);

        // Full FIFO with a pop in the push cycle: nothing lost, no overflow.
        for (int i = 0; i < 4; i++) send_frame(0, 8'h11 + 8'(i), 0, 0, 0, -1);
        send_frame(0, 8'h15, 0, 0, 1, -1);
        status_is(0, "full_pop", 4, 0);
        for (int i = 0; i < 4; i++) begin
            head_is(0, "full_pop_drain", 8'h12 + 8'(i), 0, 0);
            pop(0);
        end

        // Reset in the middle of data bit 3; 0xF8 keeps the line high afterwards.
        send_frame(0, 8'h66, 0, 0, 0, -1);
        send_frame(0, 8'hF8, 0, 0, 0, 70);
        status_is(0, "after_reset", 0, 0);
        send_frame(0, 8'h5A, 0, 0, 0, -1);
        head_is(0, "after_reset", 8'h5A, 0, 0);
        pop(0);

        // Randomised traffic on both instances.
        for (int i = 0; i < 40; i++) begin
            w  = int'($urandom_range(0, 1));
            d  = 8'($urandom);
            pb = ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 7) == 0);
            send_frame(w, d, pb, sb, 0, -1);
            npop = int'($urandom_range(0, 2));
            for (int j = 0; j < npop; j++) pop(int'($urandom_range(0, 1)));
            if ($urandom_range(0, 5) == 0) clr(w);
        end
        for (int j = 0; j < 5; j++) begin
            pop(0);
            pop(1);
        end
        status_is(0, "final_n", 0, ovf_m[0]);
        status_is(1, "final_p", 0, ovf_m[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver that serves the same CPU-facing role as the existing single-channel receiver. It decodes asynchronous serial frames with configurable data width, parity and stop bits, and validates the start bit to reject line glitches. Each received word goes into a power-of-two FIFO together with its per-word parity and framing error flags. It sits between the board RX pin and the core's memory-mapped UART status/data registers.

## Interface
- CLK_FREQ, 125_000_000, system clock frequency in Hz
- BAUD, 115200, line rate; BAUD_CNT = CLK_FREQ/BAUD (integer divide, must be ≥ 8)
- DATA_BITS, 8, data bits per frame, legal 5..9
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, 1 or 2
- FIFO_DEPTH, 4, entries, power of two, ≥ 2; AW = log2(FIFO_DEPTH)

Ports:
- clk  in  1  single system clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- rx  in  1  serial line, idle high, asynchronous to clk
- rx_data  out  DATA_BITS  FIFO head data, valid while rx_ready = 1
- rx_err_parity  out  1  parity error flag of head entry (0 when PARITY = 0)
- rx_err_frame  out  1  framing error flag of head entry
- rx_ready  out  1  FIFO not empty
- rx_ack  in  1  one-cycle pop strobe; ignored when FIFO empty
- rx_count  out  AW+1  entries currently stored, 0..FIFO_DEPTH
- overflow  out  1  sticky: a complete frame was dropped because the FIFO was full
- ovf_clr  in  1  clears overflow; a drop in the same cycle wins and keeps it set

## Operation
- rx passes through a 2-flop synchroniser (reset value 1) to give rx_s. A start condition is rx_s falling from 1 to 0.
- State machine: IDLE, START, DATA, PARITY, STOP, BREAK. All states use one 16-bit down counter cnt.
- IDLE: on start condition, load cnt = BAUD_CNT/2 − 1 and go to START.
- START: at cnt = 0, sample rx_s.
  - 1 → glitch: back to IDLE, nothing pushed.
  - 0 → load cnt = BAUD_CNT − 1, clear bit index, go to DATA.
- DATA: each time cnt reaches 0, sample rx_s into bit[index] (LSB first) and reload BAUD_CNT − 1. After DATA_BITS samples, go to PARITY if PARITY ≠ 0, else STOP.
- PARITY: sample one bit. perr = (XOR of data bits and parity bit) ≠ (PARITY == 2 ? 1 : 0).
- STOP: sample STOP_BITS bits one period apart; ferr = 1 if any stop sample is 0. At the last stop sample the push is issued in the same cycle.
  - All stop samples 1 → go to IDLE.
  - Last stop sample 0 → go to BREAK.
- BREAK: wait for rx_s = 1, then go to IDLE. A held-low line yields exactly one entry, with ferr = 1.
- FIFO: storage of {ferr, perr, data}, with wr_ptr/rd_ptr of AW bits that wrap modulo FIFO_DEPTH, plus a count register.
  - push && !full → write at wr_ptr.
  - pop = rx_ack && count ≠ 0.
  - push && full && pop → both occur, count unchanged, no overflow.
  - push && full && !pop → word dropped, overflow set.
- Outputs rx_data, rx_err_* come combinationally from storage[rd_ptr]. They are don't-care when empty and are not gated.

## Timing
- Reset values:
  - rx_ready = 0, rx_count = 0, overflow = 0.
  - rx_data, rx_err_parity, rx_err_frame = 0 (storage cleared).
  - State IDLE, pointers 0.
- Reset mid-frame aborts the frame: no push, FIFO emptied.
- Pin to start detect: 2 clk synchroniser + 1 edge cycle. Samples are taken at bit centres ±1 clk.
- Push to visible: rx_count and rx_ready update on the clock edge after the last stop sample, so they are high 1 cycle after it.
- Pop: rx_ack sampled at edge N. rd_ptr, count and head outputs change after edge N. Back-to-back acks pop one entry per cycle.
- Earliest next frame: start condition accepted in the cycle IDLE is re-entered.

## Test plan
- CLK_FREQ=1_600_000, BAUD=100_000 (BAUD_CNT=16), 8N1: send 0xA5 → rx_ready rises 1 clk after the stop centre; rx_data=0xA5, errs=0, rx_count=1; one rx_ack → rx_count=0, rx_ready=0.
- rx low pulse of 4 clk in idle → state returns to IDLE at the half-bit sample; rx_count stays 0. Then send valid 0x3C → received 0x3C.
- PARITY=1, send 0x07 with parity bit 0 → rx_err_parity=1, rx_data=0x07. Send 0x07 with parity bit 1 → rx_err_parity=0.
- Hold rx low for 30 bit times → exactly one entry: data 0x00, rx_err_frame=1. After rx returns high, 0x81 is received cleanly.
- FIFO_DEPTH=4, send 0x01..0x05 with no ack → rx_count=4, overflow=1, head 0x01. Pop 4 entries → 0x01..0x04 in order. ovf_clr → overflow=0. Next, with FIFO full and rx_ack asserted in the push cycle → rx_count stays 4, overflow stays 0, last entry kept.
- Assert resetn=0 mid data bit 3, then release during the same frame → no entry from the aborted frame, all outputs at reset values; next full frame 0x5A is received.
